// File: rtl/rv32i_types.sv
// Shared RV32I core types: ROB commit record and per-entry storage for the reorder buffer.
package rv32i_types;

    localparam int ROB_SIZE = 16;

    typedef struct packed {
        logic [4:0]  rds;
        logic [31:0] ROB_val;
        logic        br_en;
        logic [31:0] br_target;
    } rob_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        br_en;
        logic [31:0] br_target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation at dispatch, CDB capture with lookup bypass,
// in-order commit (one per cycle, consumer always accepts) and flush on a redirecting branch.
module reorder_buffer
    import rv32i_types::*;
#(
    parameter int SIZE = ROB_SIZE,
    localparam int TW  = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dispatch,
    input  logic [4:0]    dispatch_rd,
    output logic [TW-1:0] rob_entry,
    output logic          rob_full,
    input  logic          cdb_valid,
    input  logic [TW-1:0] cdb_tag,
    input  logic [31:0]   cdb_value,
    input  logic          cdb_br_en,
    input  logic [31:0]   cdb_br_target,
    input  logic [TW-1:0] tag1,
    input  logic [TW-1:0] tag2,
    input  logic          tag1_valid,
    input  logic          tag2_valid,
    output logic          tag1_ready,
    output logic          tag2_ready,
    output logic [31:0]   tag1_value,
    output logic [31:0]   tag2_value,
    output logic          ready,
    output logic [TW-1:0] ROB_commit_tag,
    output rob_t          rdest
);

    rob_entry_t    entries [SIZE];
    logic [TW-1:0] head;
    logic [TW-1:0] tail;
    logic [TW:0]   count;

    rob_entry_t head_entry;
    logic       flush;
    logic       do_dispatch;
    logic       hit1;
    logic       hit2;

    assign head_entry     = entries[head];
    assign ready          = head_entry.valid && head_entry.done;
    assign flush          = ready && head_entry.br_en;
    // Full is judged on the pre-commit count, so a commit never frees a slot in the same cycle.
    assign rob_full       = (count == (TW+1)'(SIZE));
    assign do_dispatch    = dispatch && !rob_full;
    assign rob_entry      = tail;
    assign ROB_commit_tag = head;

    always_comb begin
        rdest = '0;
        if (ready) begin
            rdest.rds       = head_entry.rd;
            rdest.ROB_val   = (head_entry.rd == 5'd0) ? 32'd0 : head_entry.value;
            rdest.br_en     = head_entry.br_en;
            rdest.br_target = head_entry.br_target;
        end
    end

    assign hit1       = cdb_valid && (cdb_tag == tag1);
    assign hit2       = cdb_valid && (cdb_tag == tag2);
    assign tag1_ready = tag1_valid && entries[tag1].valid && (entries[tag1].done || hit1);
    assign tag2_ready = tag2_valid && entries[tag2].valid && (entries[tag2].done || hit2);
    assign tag1_value = !tag1_ready ? 32'd0 : (hit1 ? cdb_value : entries[tag1].value);
    assign tag2_value = !tag2_ready ? 32'd0 : (hit2 ? cdb_value : entries[tag2].value);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) entries[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            // Redirect: younger work is on the wrong path, including this cycle's dispatch and CDB.
            for (int i = 0; i < SIZE; i++) entries[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cdb_valid && entries[cdb_tag].valid) begin
                entries[cdb_tag].done      <= 1'b1;
                entries[cdb_tag].value     <= cdb_value;
                entries[cdb_tag].br_en     <= cdb_br_en;
                entries[cdb_tag].br_target <= cdb_br_target;
            end
            if (ready) begin
                entries[head].valid <= 1'b0;
                entries[head].done  <= 1'b0;
            end
            if (do_dispatch) begin
                entries[tail].valid     <= 1'b1;
                entries[tail].done      <= 1'b0;
                entries[tail].rd        <= dispatch_rd;
                entries[tail].value     <= 32'd0;
                entries[tail].br_en     <= 1'b0;
                entries[tail].br_target <= 32'd0;
            end
            head  <= head + TW'(ready);
            tail  <= tail + TW'(do_dispatch);
            count <= count + (TW+1)'(do_dispatch) - (TW+1)'(ready);
        end
    end

endmodule
